// File: rtl/alg_amba_vip_stats_pkg.sv
// Shared widths, typedefs and sizing helpers for the per-ID latency statistics monitor.
package alg_amba_vip_stats_pkg;

    localparam int STAT_TOTAL_W  = 64;
    localparam int STAT_NB_W     = 56;
    localparam int HIST_W        = 32;
    localparam int LAT_W_DEFAULT = 16;

    typedef logic [LAT_W_DEFAULT-1:0] latency_t;

    function automatic int id_w(input int num_ids);
        return (num_ids > 1) ? $clog2(num_ids) : 1;
    endfunction

    function automatic int bin_w(input int nb_bins);
        return (nb_bins > 1) ? $clog2(nb_bins) : 1;
    endfunction

endpackage

// File: rtl/alg_amba_vip_base_fifo.sv
// Show-ahead timestamp queue; one instance holds the outstanding requests of one ID.
module alg_amba_vip_base_fifo #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wreq_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rreq_i,
    output logic [DW-1:0] rdata_o,
    output logic          wfull_o,
    output logic          rempty_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   wptr_d;
    logic [AW:0]   rptr_q;
    logic [AW:0]   rptr_d;
    logic          do_wr_s;
    logic          do_rd_s;

    assign rempty_o = (wptr_q == rptr_q);
    assign wfull_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o  = mem_q[rptr_q[AW-1:0]];

    // A full queue still takes a write when its head leaves in the same cycle.
    always_comb begin
        do_rd_s = rreq_i && !rempty_o;
        do_wr_s = wreq_i && (!wfull_o || do_rd_s);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_wr_s) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (do_rd_s) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= {(AW+1){1'b0}};
            rptr_q <= {(AW+1){1'b0}};
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/alg_amba_vip_id_delay_stats.sv
// Passive monitor: per-ID request->ack latency with totals, min/max, histogram and sticky errors.
module alg_amba_vip_id_delay_stats
    import alg_amba_vip_stats_pkg::*;
#(
    parameter int NUM_IDS              = 4,
    parameter int TIMER_WIDTH          = 16,
    parameter int OUTSTANDING_LOG2_MAX = 6,
    parameter int NB_BINS              = 16,
    parameter int BIN_SHIFT            = 2,
    localparam int ID_W                = id_w(NUM_IDS),
    localparam int BIN_W               = bin_w(NB_BINS)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cnt_rst,
    input  logic                    send_valid,
    input  logic [ID_W-1:0]         send_id,
    input  logic                    ack_valid,
    input  logic [ID_W-1:0]         ack_id,
    input  logic [BIN_W-1:0]        hist_sel,
    output logic [STAT_TOTAL_W-1:0] delay_total,
    output logic [STAT_NB_W-1:0]    nb_request,
    output logic [TIMER_WIDTH-1:0]  max_value_req,
    output logic [TIMER_WIDTH-1:0]  min_value_req,
    output logic [HIST_W-1:0]       hist_count,
    output logic                    err_fifo_full,
    output logic                    err_fifo_empty,
    output logic                    err_nbreq_overflow,
    output logic                    err_total_overflow
);

    localparam int ID_SLOTS = 1 << ID_W;

    logic [TIMER_WIDTH-1:0]  timer_q;
    logic [TIMER_WIDTH-1:0]  head_s [ID_SLOTS];
    logic [ID_SLOTS-1:0]     rempty_s;
    logic [ID_SLOTS-1:0]     wfull_s;
    logic                    pop_s;
    logic                    full_err_s;
    logic                    empty_err_s;
    logic [TIMER_WIDTH-1:0]  lat_s;
    logic [TIMER_WIDTH-1:0]  lat_shift_s;
    logic [BIN_W-1:0]        bin_s;
    logic [STAT_TOTAL_W:0]   total_sum_s;

    logic [STAT_TOTAL_W-1:0] total_q, total_d;
    logic [STAT_NB_W-1:0]    nb_q, nb_d;
    logic [TIMER_WIDTH-1:0]  max_q, max_d;
    logic [TIMER_WIDTH-1:0]  min_q, min_d;
    logic [HIST_W-1:0]       hist_q [NB_BINS];
    logic [HIST_W-1:0]       hist_d [NB_BINS];
    logic                    err_full_q, err_full_d;
    logic                    err_empty_q, err_empty_d;
    logic                    err_nb_q, err_nb_d;
    logic                    err_total_q, err_total_d;

    // Unused ID codes (NUM_IDS not a power of two) look permanently empty and full.
    for (genvar g = 0; g < ID_SLOTS; g++) begin : g_id
        if (g < NUM_IDS) begin : g_fifo
            alg_amba_vip_base_fifo #(
                .DW (TIMER_WIDTH),
                .AW (OUTSTANDING_LOG2_MAX)
            ) u_fifo (
                .clk      (clk),
                .rstn     (rstn),
                .wreq_i   (send_valid && (send_id == ID_W'(g))),
                .wdata_i  (timer_q),
                .rreq_i   (pop_s && (ack_id == ID_W'(g))),
                .rdata_o  (head_s[g]),
                .wfull_o  (wfull_s[g]),
                .rempty_o (rempty_s[g])
            );
        end else begin : g_pad
            assign head_s[g]   = {TIMER_WIDTH{1'b0}};
            assign wfull_s[g]  = 1'b1;
            assign rempty_s[g] = 1'b1;
        end
    end

    assign pop_s       = ack_valid && !rempty_s[ack_id];
    assign empty_err_s = ack_valid && rempty_s[ack_id];
    assign full_err_s  = send_valid && wfull_s[send_id] && !(pop_s && (ack_id == send_id));
    assign lat_s       = timer_q - head_s[ack_id];

    // Free-running timestamp; only rstn clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            timer_q <= {TIMER_WIDTH{1'b0}};
        end else begin
            timer_q <= timer_q + TIMER_WIDTH'(1);
        end
    end

    // Next-state statistics; cnt_rst wins over a same-cycle measured ack.
    always_comb begin
        total_sum_s = {1'b0, total_q} + {{(STAT_TOTAL_W+1-TIMER_WIDTH){1'b0}}, lat_s};
        lat_shift_s = lat_s >> BIN_SHIFT;
        if (lat_shift_s > TIMER_WIDTH'(NB_BINS-1)) begin
            bin_s = BIN_W'(NB_BINS-1);
        end else begin
            bin_s = lat_shift_s[BIN_W-1:0];
        end
        total_d     = total_q;
        nb_d        = nb_q;
        max_d       = max_q;
        min_d       = min_q;
        hist_d      = hist_q;
        err_full_d  = err_full_q;
        err_empty_d = err_empty_q;
        err_nb_d    = err_nb_q;
        err_total_d = err_total_q;
        if (cnt_rst) begin
            total_d     = {STAT_TOTAL_W{1'b0}};
            nb_d        = {STAT_NB_W{1'b0}};
            max_d       = {TIMER_WIDTH{1'b0}};
            min_d       = {TIMER_WIDTH{1'b1}};
            hist_d      = '{default: {HIST_W{1'b0}}};
            err_full_d  = 1'b0;
            err_empty_d = 1'b0;
            err_nb_d    = 1'b0;
            err_total_d = 1'b0;
        end else begin
            err_full_d  = err_full_q | full_err_s;
            err_empty_d = err_empty_q | empty_err_s;
            if (pop_s) begin
                total_d     = total_sum_s[STAT_TOTAL_W-1:0];
                err_total_d = err_total_q | total_sum_s[STAT_TOTAL_W];
                nb_d        = nb_q + STAT_NB_W'(1);
                err_nb_d    = err_nb_q | (&nb_q);
                if (lat_s > max_q) begin
                    max_d = lat_s;
                end else begin
                    max_d = max_q;
                end
                if (lat_s < min_q) begin
                    min_d = lat_s;
                end else begin
                    min_d = min_q;
                end
                if (&hist_q[bin_s]) begin
                    hist_d[bin_s] = hist_q[bin_s];
                end else begin
                    hist_d[bin_s] = hist_q[bin_s] + HIST_W'(1);
                end
            end else begin
                total_d = total_q;
            end
        end
    end

    // Statistics and error registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            total_q     <= {STAT_TOTAL_W{1'b0}};
            nb_q        <= {STAT_NB_W{1'b0}};
            max_q       <= {TIMER_WIDTH{1'b0}};
            min_q       <= {TIMER_WIDTH{1'b1}};
            hist_q      <= '{default: {HIST_W{1'b0}}};
            err_full_q  <= 1'b0;
            err_empty_q <= 1'b0;
            err_nb_q    <= 1'b0;
            err_total_q <= 1'b0;
        end else begin
            total_q     <= total_d;
            nb_q        <= nb_d;
            max_q       <= max_d;
            min_q       <= min_d;
            hist_q      <= hist_d;
            err_full_q  <= err_full_d;
            err_empty_q <= err_empty_d;
            err_nb_q    <= err_nb_d;
            err_total_q <= err_total_d;
        end
    end

    assign delay_total        = total_q;
    assign nb_request         = nb_q;
    assign max_value_req      = max_q;
    assign min_value_req      = min_q;
    assign hist_count         = hist_q[hist_sel];
    assign err_fifo_full      = err_full_q;
    assign err_fifo_empty     = err_empty_q;
    assign err_nbreq_overflow = err_nb_q;
    assign err_total_overflow = err_total_q;

endmodule
